// File: rtl/clock_mode_ctrl_if.sv
// CLKSET request/response bundle between the register front-end (master)
// and the clock mode controller (slave).
interface clock_mode_ctrl_if;
  logic       req;      // CLKSET request, held until ack
  logic [7:0] wdata;    // [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL
  logic       ack;      // one-cycle acceptance pulse
  logic       busy;     // transaction or reset stretch in progress
  logic [6:0] cfg;      // CLK[6:0] to the clock generator
  logic       res_out;  // stretched chip reset

  modport master (
    output req, wdata,
    input  ack, busy, cfg, res_out
  );

  modport slave (
    input  req, wdata,
    output ack, busy, cfg, res_out
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Clock mode controller: applies CLKSET requests to the clock generator
// configuration, waiting for PLL/oscillator settle before switching CLKSEL
// onto a newly enabled source, and stretching the chip reset.
// Optional feature macro: CLKSET_SETTLE_EN (SETTLE/APPLY settle path).
// Without it every non-reset request is applied immediately.
module clock_mode_ctrl #(
  parameter int SETTLE_CYCLES = 1600000,
  parameter int RES_CYCLES    = 16
) (
  input  logic              clock_160,
  input  logic              res,
  clock_mode_ctrl_if.slave  bus
);

  if (SETTLE_CYCLES < 1 || RES_CYCLES < 1) begin : g_param_check
    $error("clock_mode_ctrl: SETTLE_CYCLES and RES_CYCLES must be >= 1");
  end

`ifdef CLKSET_SETTLE_EN
  localparam int CNT_MAX = (SETTLE_CYCLES > RES_CYCLES) ? SETTLE_CYCLES : RES_CYCLES;
`else
  localparam int CNT_MAX = RES_CYCLES;
`endif
  // Counter only ever holds values up to CNT_MAX-1, so $clog2 is enough.
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, APPLY, STRETCH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         cfg_q, cfg_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               res_out_q, res_out_d;
  logic               armed_q, armed_d;
`ifdef CLKSET_SETTLE_EN
  logic [2:0]         clksel_q, clksel_d;
`endif

  // Control state and registered outputs; reset forces safe RCFAST config.
  always_ff @(posedge clock_160) begin
    if (res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cfg_q     <= 7'h00;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      res_out_q <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      res_out_q <= res_out_d;
      armed_q   <= armed_d;
    end
  end

`ifdef CLKSET_SETTLE_EN
  // Pending CLKSEL captured at accept; only consumed after a full settle.
  always_ff @(posedge clock_160) begin
    clksel_q <= clksel_d;
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    res_out_d = res_out_q;
    armed_d   = armed_q | ~bus.req;
`ifdef CLKSET_SETTLE_EN
    clksel_d  = clksel_q;
`endif
    case (state_q)
      IDLE: begin
        if (res_out_q) begin
          // Only reachable straight out of reset: keep res_out high for the stretch.
          state_d = STRETCH;
          cnt_d   = CNT_W'(RES_CYCLES - 1);
          busy_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
          if (bus.req && armed_q) begin
            armed_d = 1'b0;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
            if (bus.wdata[7]) begin
              cfg_d     = 7'h00;
              res_out_d = 1'b1;
              cnt_d     = CNT_W'(RES_CYCLES - 1);
              state_d   = STRETCH;
            end
`ifdef CLKSET_SETTLE_EN
            else if (|(bus.wdata[6:5] & ~cfg_q[6:5])) begin
              // Newly enabled source: switch enables now, keep old CLKSEL until settled.
              cfg_d    = {bus.wdata[6:3], cfg_q[2:0]};
              clksel_d = bus.wdata[2:0];
              cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
              state_d  = SETTLE;
            end
`endif
            else begin
              cfg_d   = bus.wdata[6:0];
              state_d = APPLY;
            end
          end
        end
      end
`ifdef CLKSET_SETTLE_EN
      SETTLE: begin
        if (cnt_q == '0) begin
          cfg_d[2:0] = clksel_q;
          state_d    = APPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      APPLY: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      STRETCH: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          res_out_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.cfg     = cfg_q;
  assign bus.res_out = res_out_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Testbench for clock_mode_ctrl: directed scenarios plus randomized CLKSET
// requests checked against a transaction-level timeline model.
module tb_clock_mode_ctrl;

  localparam int SETTLE = 8;
  localparam int RES    = 4;
`ifdef CLKSET_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] model_cfg = 7'h00;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .RES_CYCLES    (RES)
  ) dut (
    .clock_160 (clk),
    .res       (res),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check_outputs(input string tag, input logic [6:0] e_cfg,
                               input logic e_busy, input logic e_res_out, input logic e_ack);
    checks++;
    assert (bus.cfg === e_cfg) else begin
      errors++;
      $error("FAIL %s cfg: observed=%h expected=%h", tag, bus.cfg, e_cfg);
    end
    checks++;
    assert (bus.busy === e_busy) else begin
      errors++;
      $error("FAIL %s busy: observed=%b expected=%b", tag, bus.busy, e_busy);
    end
    checks++;
    assert (bus.res_out === e_res_out) else begin
      errors++;
      $error("FAIL %s res_out: observed=%b expected=%b", tag, bus.res_out, e_res_out);
    end
    checks++;
    assert (bus.ack === e_ack) else begin
      errors++;
      $error("FAIL %s ack: observed=%b expected=%b", tag, bus.ack, e_ack);
    end
  endtask

  // Hold reset for n edges, then release and follow the stretch to idle.
  task automatic do_reset(input int n);
    res     = 1'b1;
    bus.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_outputs("rst_hold", 7'h00, 1'b1, 1'b1, 1'b0);
    res = 1'b0;
    for (int k = 1; k <= RES + 1; k++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("rst_rel_k%0d", k), 7'h00, k <= RES, k <= RES, 1'b0);
    end
    model_cfg = 7'h00;
  endtask

  // One CLKSET request; k counts sample points after the accepting edge.
  // hold: extra cycles req stays high after ack. abort_k: raise res after check k.
  task automatic txn(input string name, input logic [7:0] w, input int hold, input int abort_k);
    logic       rstreq, settle;
    logic [6:0] full, part;
    int         lat, win;
    rstreq = w[7];
    settle = SETTLE_EN && !rstreq && ((w[6] && !model_cfg[6]) || (w[5] && !model_cfg[5]));
    full   = rstreq ? 7'h00 : w[6:0];
    part   = settle ? {w[6:3], model_cfg[2:0]} : full;
    lat    = settle ? SETTLE + 1 : (rstreq ? RES : 1);
    win    = (lat + 1 > hold + 2) ? lat + 1 : hold + 2;
    bus.wdata = w;
    bus.req   = 1'b1;
    for (int k = 1; k <= win; k++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("%s_k%0d", name, k), (settle && k <= SETTLE) ? part : full,
                    k <= lat, rstreq && k <= lat, k == 1);
      if (k >= hold + 1) bus.req = 1'b0;
      bus.wdata = 8'($urandom);
      if (abort_k != 0 && k == abort_k) begin
        bus.req   = 1'b0;
        res       = 1'b1;
        model_cfg = 7'h00;
        return;
      end
    end
    model_cfg = full;
    @(posedge clk);
    #1;
    check_outputs({name, "_gap"}, model_cfg, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    int         hold;
    bus.req   = 1'b0;
    bus.wdata = 8'h00;

    do_reset(3);
    txn("en_pll_osc", 8'h6F, 0, 0);
    txn("sel_only", 8'h6E, 0, 0);
    txn("disable_osc", 8'h4A, 1, 0);
    txn("sw_reset", 8'h80, 6, 0);
    txn("abort", 8'h6F, 0, 4);
    do_reset(2);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_abort_k%0d", k), 7'h00, 1'b0, 1'b0, 1'b0);
    end
    txn("reenable", 8'h2D, 2, 0);

    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom);
      if (w[7] && $urandom_range(0, 3) != 0) w[7] = 1'b0;
      hold = $urandom_range(0, 3);
      txn($sformatf("rnd%0d", i), w, hold, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1600000: settle wait (10 ms at 160 MHz) after newly enabling the PLL or oscillator.
REQ-002 SHALL have parameter RES_CYCLES, default 16: length of the reset-stretch pulse.
REQ-003 SHALL have port clock_160  input  1: single clock (free-running 160 MHz); all logic rises on it.
REQ-004 SHALL have port res  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1: CLKSET request, held until ack.
REQ-006 SHALL have port wdata  input  8: requested CLK value; [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
REQ-007 SHALL have port ack  output  1: one-cycle acceptance pulse.
REQ-008 SHALL have port busy  output  1: transaction or reset stretch in progress.
REQ-009 SHALL have port cfg  output  7: CLK[6:0] driven to the clock generator's cfg input.
REQ-010 SHALL have port res_out  output  1: chip reset to the clock generator and the rest of the design.

Function
REQ-011 SHALL implement the states IDLE, SETTLE, APPLY and STRETCH, with all outputs registered.
REQ-012 SHALL accept a request in IDLE only when req=1 and req was sampled low at least once since the previous accept (armed flag).
REQ-013 SHALL pulse ack high for exactly the cycle after the accepting edge N, and SHALL hold busy high from N+1 until the state returns to IDLE.
REQ-014 Immediate path: if wdata[7]=0 and wdata[6:5] enables no bit that is 0 in the current cfg[6:5], it SHALL set cfg=wdata[6:0] at N+1, set busy for one cycle, and return to IDLE.
REQ-015 Settle path, entered when wdata[7]=0 and wdata[6:5] sets a bit that is currently 0:
- at N+1: cfg={wdata[6:3], old cfg[2:0]}; state=SETTLE; counter=SETTLE_CYCLES-1.
- the counter SHALL decrement each cycle; at 0 the state SHALL go to APPLY.
- APPLY SHALL load cfg[2:0]=wdata[2:0]; full value visible at N+1+SETTLE_CYCLES; then IDLE.
REQ-016 SHALL store wdata at accept; wdata and req changes during SETTLE SHALL have no effect.
REQ-017 Disables SHALL take effect together with the new CLKSEL at N+1; no ordering check of the CLKSEL/enable combination is performed.
REQ-018 If wdata[7]=1, the block SHALL set cfg=7'h00 at N+1 and enter STRETCH; other wdata bits are ignored.
REQ-019 STRETCH SHALL hold res_out=1 and busy=1 for exactly RES_CYCLES cycles, then go to IDLE with res_out=0.
REQ-020 SETTLE_CYCLES and RES_CYCLES SHALL each be >=1; the counter width SHALL be $clog2 of the larger parameter, and the counter SHALL not wrap.

Reset
REQ-021 While res=1: cfg=7'h00 (RCFAST), ack=0, busy=1, res_out=1, armed=0, counter cleared.
REQ-022 On the first edge with res=0, the block SHALL enter STRETCH, so res_out stays high RES_CYCLES further cycles.
REQ-023 res asserted in any state, including mid-SETTLE, SHALL abort the transaction and apply REQ-021 on the next edge; no pending APPLY survives.

Configuration
REQ-024 Macro CLKSET_SETTLE_EN: when defined, the SETTLE/APPLY path exists as specified.
REQ-025 When CLKSET_SETTLE_EN is undefined, every non-reset request SHALL take the immediate path (REQ-014), the settle counter SHALL be absent, and SETTLE_CYCLES SHALL be ignored.

Verification (SETTLE_CYCLES=8, RES_CYCLES=4, macro defined unless noted)
REQ-026 Release res -> res_out=1 and busy=1 for 4 further cycles, cfg=0x00, then IDLE with res_out=0.
REQ-027 From cfg=0x00, req wdata=0x6F at edge N -> ack pulse at N+1; cfg=0x68 at N+1; cfg=0x6F at N+9; busy falls at N+10.
REQ-028 From cfg=0x6F, req wdata=0x6E -> cfg=0x6E at N+1; busy for one cycle; no settle.
REQ-029 req wdata=0x80 -> cfg=0x00 at N+1; res_out high cycles N+1..N+4; req held high throughout -> exactly one ack.
REQ-030 res pulsed at N+4 during the 0x6F settle -> cfg=0x00 and res_out=1; 0x6F never appears.
REQ-031 Macro undefined: wdata=0x6F -> cfg=0x6F at N+1; busy for one cycle.
